// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
// Bundle between the multicycle control FSM and the RV32I datapath.
//   instr, zero : datapath -> controller (IR contents, ALU zero flag)
//   pc_write, ior_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b[1:0], alu_ctrl[3:0], pc_source : controller -> datapath
//   state[3:0], halted, instret[CNT_W-1:0] : controller status/debug
// Modports: master = controller, slave = datapath.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic             pc_write;
  logic             ior_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [3:0]       alu_ctrl;
  logic             pc_source;
  logic [3:0]       state;
  logic             halted;
  logic [CNT_W-1:0] instret;

  modport master (
    input  instr, zero,
    output pc_write, ior_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_source,
           state, halted, instret
  );

  modport slave (
    output instr, zero,
    input  pc_write, ior_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_source,
           state, halted, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Main control FSM for the multicycle RV32I datapath (lw, sw, addi,
// add/sub/and/or, beq). Moore machine: control outputs are decoded from the
// current state and IR; pc_write additionally folds in the ALU zero flag.
// Also maintains a retired-instruction counter.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   bus    : multicycle_ctrl_if.master (instr/zero in, controls/status out)
// Optional build macro: ILLEGAL_HALT_EN -- illegal instructions park the FSM
//   in HALT (halted=1) until reset; otherwise they are skipped.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_HALT    = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  state_t           state_q;
  logic [CNT_W-1:0] instret_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  // Register indices and immediates belong to the datapath, not to control.
  assign unused_instr_bits = ^{bus.instr[24:15], bus.instr[11:7]};

  // Full legality check, including funct fields, so illegal ALU ops are
  // caught in DECODE before EXEC would drive anything.
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_BEQ: ok = 1'b1;
      OP_IMM: ok = (f3 == 3'b000);
      OP_ALU: ok = ({f7, f3} == {7'b0000000, 3'b000}) ||
                   ({f7, f3} == {7'b0100000, 3'b000}) ||
                   ({f7, f3} == {7'b0000000, 3'b111}) ||
                   ({f7, f3} == {7'b0000000, 3'b110});
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] rtype_alu(input logic [2:0] f3,
                                           input logic [6:0] f7);
    logic [3:0] code;
    code = ALU_ADD;
    case ({f7, f3})
      {7'b0100000, 3'b000}: code = ALU_SUB;
      {7'b0000000, 3'b111}: code = ALU_AND;
      {7'b0000000, 3'b110}: code = ALU_OR;
      default:              code = ALU_ADD;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (!is_legal(opcode, funct3, funct7)) begin
`ifdef ILLEGAL_HALT_EN
            state_q <= S_HALT;
`else
            // Skipped: PC already advanced in FETCH, nothing retires.
            state_q <= S_FETCH;
`endif
          end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
            state_q <= S_MEMADDR;
          end else if (opcode == OP_BEQ) begin
            state_q <= S_BRANCH;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_MEMADDR: state_q <= (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   state_q <= S_MEMWB;
        S_EXEC:    state_q <= S_ALUWB;
        S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH: begin
          state_q   <= S_FETCH;
          instret_q <= instret_q + 1'b1;
        end
`ifdef ILLEGAL_HALT_EN
        S_HALT:    state_q <= S_HALT;
`endif
        default:   state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    logic pc_write_uncond;
    logic branch;
    pc_write_uncond = 1'b0;
    branch          = 1'b0;
    bus.ior_d       = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_write   = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.alu_ctrl    = ALU_ADD;
    bus.pc_source   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read    = 1'b1;
        bus.ir_write    = 1'b1;
        bus.alu_src_b   = 2'b01;
        pc_write_uncond = 1'b1;
      end
      // ALUOut <= PC+4+imm, i.e. the branch target of the current beq.
      S_DECODE: bus.alu_src_b = 2'b10;
      S_MEMADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.ior_d     = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        if (opcode == OP_IMM) begin
          bus.alu_src_b = 2'b10;
        end else begin
          bus.alu_ctrl = rtype_alu(funct3, funct7);
        end
      end
      S_ALUWB: bus.reg_write = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = ALU_SUB;
        bus.pc_source = 1'b1;
        branch        = 1'b1;
      end
      default: ;
    endcase
    bus.pc_write = pc_write_uncond | (branch & bus.zero);
    // Keep architectural state untouched while reset is held.
    if (reset) begin
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
    end
  end

  assign bus.state   = state_q;
  assign bus.instret = instret_q;
`ifdef ILLEGAL_HALT_EN
  assign bus.halted  = (state_q == S_HALT);
`else
  assign bus.halted  = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl: walks addi, lw, sw, beq (taken and
// not taken), R-type ALU decodes, reset during MEMRD and an illegal
// instruction (behaviour selected by ILLEGAL_HALT_EN).
module tb_multicycle_ctrl;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.instr = 32'h0000_0013;
    bus.zero  = 1'b0;
    tick();
    chk("rst_state", {28'd0, bus.state}, 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    chk("rst_pc_write_forced", {31'd0, bus.pc_write}, 32'd0);
    chk("rst_ir_write_forced", {31'd0, bus.ir_write}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    reset = 1'b0;
    #1;
    chk("fetch_pc_write", {31'd0, bus.pc_write}, 32'd1);
    chk("fetch_ir_write", {31'd0, bus.ir_write}, 32'd1);
    chk("fetch_mem_read", {31'd0, bus.mem_read}, 32'd1);
    chk("fetch_alu_src_b", {30'd0, bus.alu_src_b}, 32'd1);

    // addi x0,x0,5
    bus.instr = 32'h0050_0013;
    tick();
    chk("addi_s1", {28'd0, bus.state}, 32'd1);
    chk("dec_alu_src_b", {30'd0, bus.alu_src_b}, 32'd2);
    tick();
    chk("addi_s2", {28'd0, bus.state}, 32'd6);
    chk("addi_srcb", {30'd0, bus.alu_src_b}, 32'd2);
    chk("addi_srca", {31'd0, bus.alu_src_a}, 32'd1);
    chk("addi_alu", {28'd0, bus.alu_ctrl}, 32'h2);
    tick();
    chk("addi_s3", {28'd0, bus.state}, 32'd7);
    chk("aluwb_reg_write", {31'd0, bus.reg_write}, 32'd1);
    chk("aluwb_mem_to_reg", {31'd0, bus.mem_to_reg}, 32'd0);
    tick();
    chk("addi_s4", {28'd0, bus.state}, 32'd0);
    chk("addi_instret", bus.instret, 32'd1);

    // lw x2,-50(x1)
    bus.instr = 32'hFCE0_A103;
    tick();
    chk("lw_s1", {28'd0, bus.state}, 32'd1);
    tick();
    chk("lw_s2", {28'd0, bus.state}, 32'd2);
    chk("memaddr_srcb", {30'd0, bus.alu_src_b}, 32'd2);
    tick();
    chk("lw_s3", {28'd0, bus.state}, 32'd3);
    chk("memrd_ior_d", {31'd0, bus.ior_d}, 32'd1);
    chk("memrd_mem_read", {31'd0, bus.mem_read}, 32'd1);
    tick();
    chk("lw_s4", {28'd0, bus.state}, 32'd4);
    chk("memwb_reg_write", {31'd0, bus.reg_write}, 32'd1);
    chk("memwb_mem_to_reg", {31'd0, bus.mem_to_reg}, 32'd1);
    tick();
    chk("lw_s5", {28'd0, bus.state}, 32'd0);
    chk("lw_instret", bus.instret, 32'd2);

    // sw x3,-20(x1)
    bus.instr = 32'hFE30_A623;
    tick();
    tick();
    chk("sw_s2", {28'd0, bus.state}, 32'd2);
    tick();
    chk("sw_s3", {28'd0, bus.state}, 32'd5);
    chk("memwr_mem_write", {31'd0, bus.mem_write}, 32'd1);
    chk("memwr_ior_d", {31'd0, bus.ior_d}, 32'd1);
    chk("memwr_reg_write", {31'd0, bus.reg_write}, 32'd0);
    tick();
    chk("sw_s4", {28'd0, bus.state}, 32'd0);
    chk("sw_instret", bus.instret, 32'd3);

    // beq taken
    bus.instr = 32'h0020_8463;
    bus.zero  = 1'b1;
    tick();
    tick();
    chk("beq_t_s2", {28'd0, bus.state}, 32'd8);
    chk("beq_t_pc_write", {31'd0, bus.pc_write}, 32'd1);
    chk("beq_t_pc_source", {31'd0, bus.pc_source}, 32'd1);
    chk("beq_t_alu", {28'd0, bus.alu_ctrl}, 32'h6);
    tick();
    chk("beq_t_s3", {28'd0, bus.state}, 32'd0);
    chk("beq_t_instret", bus.instret, 32'd4);

    // beq not taken
    bus.zero = 1'b0;
    tick();
    tick();
    chk("beq_n_s2", {28'd0, bus.state}, 32'd8);
    chk("beq_n_pc_write", {31'd0, bus.pc_write}, 32'd0);
    tick();
    chk("beq_n_s3", {28'd0, bus.state}, 32'd0);
    chk("beq_n_instret", bus.instret, 32'd5);

    // sub, add, or
    bus.instr = 32'h4020_8033;
    tick();
    tick();
    chk("sub_state", {28'd0, bus.state}, 32'd6);
    chk("sub_alu", {28'd0, bus.alu_ctrl}, 32'h6);
    chk("sub_srcb", {30'd0, bus.alu_src_b}, 32'd0);
    tick();
    tick();
    bus.instr = 32'h0020_8033;
    tick();
    tick();
    chk("add_alu", {28'd0, bus.alu_ctrl}, 32'h2);
    tick();
    tick();
    bus.instr = 32'h0020_E033;
    tick();
    tick();
    chk("or_alu", {28'd0, bus.alu_ctrl}, 32'h1);
    tick();
    tick();
    chk("rtype_instret", bus.instret, 32'd8);

    // Reset asserted during MEMRD of a lw
    bus.instr = 32'hFCE0_A103;
    tick();
    tick();
    tick();
    chk("rstmid_in_memrd", {28'd0, bus.state}, 32'd3);
    reset = 1'b1;
    #1;
    chk("rstmid_mem_write", {31'd0, bus.mem_write}, 32'd0);
    tick();
    chk("rstmid_state", {28'd0, bus.state}, 32'd0);
    chk("rstmid_reg_write", {31'd0, bus.reg_write}, 32'd0);
    chk("rstmid_instret", bus.instret, 32'd0);
    reset = 1'b0;
    #1;

`ifdef ILLEGAL_HALT_EN
    bus.instr = 32'hFFFF_FFFF;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", {28'd0, bus.state}, 32'd9);
      chk("halt_halted", {31'd0, bus.halted}, 32'd1);
      chk("halt_pc_write", {31'd0, bus.pc_write}, 32'd0);
      tick();
    end
    chk("halt_instret", bus.instret, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("halt_exit_state", {28'd0, bus.state}, 32'd0);
    chk("halt_exit_halted", {31'd0, bus.halted}, 32'd0);
`else
    // illegal funct (mul encoding) is skipped
    bus.instr = 32'h0220_8033;
    tick();
    tick();
    chk("badfunct_state", {28'd0, bus.state}, 32'd0);
    bus.instr = 32'hFFFF_FFFF;
    tick();
    chk("illegal_s1", {28'd0, bus.state}, 32'd1);
    tick();
    chk("illegal_s2", {28'd0, bus.state}, 32'd0);
    chk("illegal_instret", bus.instret, 32'd0);
    chk("illegal_halted", {31'd0, bus.halted}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV32I datapath: it sequences the PC, IR, MDR, A/B, ALUOut registers, the unified memory and the register file through fetch/decode/execute/memory/writeback. It supports lw, sw, addi, R-type (add, sub, and, or) and beq. It decodes the IR contents into per-cycle mux selects, write enables and the 4-bit ALU control code, and it keeps a retired-instruction counter. It sits beside the datapath and is the only source of its control signals.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- instr  in  32  current IR contents (opcode [6:0], funct3 [14:12], funct7 [31:25])
- zero  in  1  ALU zero flag
- pc_write  out  1  PC load enable; already includes the beq condition (pc_write_uncond | (branch & zero))
- ior_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- ir_write  out  1  IR load enable
- mem_to_reg  out  1  register write-data select: 1 = MDR, 0 = ALUOut
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = imm
- alu_ctrl  out  4  0010 add, 0110 sub, 0000 and, 0001 or
- pc_source  out  1  0 = ALU result, 1 = ALUOut
- state  out  4  current state encoding (debug)
- halted  out  1  high in HALT (only with ILLEGAL_HALT_EN; otherwise tied 0)
- instret  out  CNT_W  retired-instruction count

## Operation
- Moore FSM; all outputs are combinational from state and instr, except pc_write, which also uses zero. Any signal not listed for a state is 0, alu_src_b = 00 and alu_ctrl = 0010.
- Encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, HALT=9.
- FETCH: mem_read, ir_write, alu_src_b=01, pc_write (PC←PC+4). Next state is DECODE.
- DECODE: alu_src_b=10, add, which leaves ALUOut = PC+4+imm (the branch target). Next state by opcode:
  - 0000011 or 0100011 → MEMADDR
  - 0110011 or 0010011 → EXEC
  - 1100011 → BRANCH
  - anything else is illegal
- MEMADDR: alu_src_a=1, alu_src_b=10, add. Next state is MEMRD for lw and MEMWR for sw.
- MEMRD: mem_read, ior_d=1. Next state is MEMWB.
- MEMWB: reg_write, mem_to_reg=1. Next state is FETCH.
- MEMWR: mem_write, ior_d=1. Next state is FETCH.
- EXEC: alu_src_a=1; alu_src_b=00 for R-type, 10 for addi. Next state is ALUWB.
  - alu_ctrl for R-type: {funct7,funct3} 0000000/000 → add, 0100000/000 → sub, 0000000/111 → and, 0000000/110 → or.
  - alu_ctrl for addi: funct3 000 → add.
  - Any other funct combination is illegal, detected in DECODE.
- ALUWB: reg_write, mem_to_reg=0. Next state is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_source=1, branch=1. pc_write = zero. Next state is FETCH.
- Branch convention: target = beq address + 4 + imm, because PC is already advanced when DECODE runs.
- instret increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH. It wraps modulo 2^CNT_W.
- x0 writes are issued normally; the register file discards them.

## Timing
- Cycles per instruction: lw 5, sw 4, R-type/addi 4, beq 3 (taken or not).
- Reset, sampled on a clk edge:
  - state→FETCH, instret→0.
  - While reset is high, pc_write, ir_write, mem_write and reg_write are forced 0 combinationally.
  - Reset mid-instruction abandons the instruction; no partial write occurs after the reset edge, and instret does not count it.
- The first FETCH is the cycle after reset deasserts: state=0, pc_write=1, ir_write=1, mem_read=1.
- instr is only decoded in DECODE, MEMADDR and EXEC. IR is stable there because ir_write is high only in FETCH.

## Configuration
- ILLEGAL_HALT_EN defined:
  - Illegal opcode/funct in DECODE → HALT.
  - HALT drives all enables 0 and halted=1, and stays there until reset. instret is frozen.
- ILLEGAL_HALT_EN undefined:
  - Illegal opcode/funct in DECODE → FETCH. The instruction is skipped (PC already +4) and instret is not incremented.
  - HALT is unreachable and halted is tied 0.

## Test plan
- Reset, then instr=0x00500013 (addi x0,x0,5): states 0,1,6,7,0. ALUWB has reg_write=1 and mem_to_reg=0. instret=1 after 4 cycles.
- instr=0xFCE0A103 (lw x2,-50(x1)): states 0,1,2,3,4. MEMRD has ior_d=1 and mem_read=1. MEMWB has reg_write=1 and mem_to_reg=1. Total 5 cycles.
- instr=0xFE30A623 (sw x3,-20(x1)): states 0,1,2,5. MEMWR has mem_write=1, ior_d=1 and reg_write=0.
- beq 0x00208463 with zero=1 in BRANCH → pc_write=1, pc_source=1. Same instruction with zero=0 → pc_write=0. Both take 3 cycles.
- R-type 0x40208033 (sub) → alu_ctrl=0110 in EXEC. Same with funct7=0x00 → 0010. funct3=110 → 0001.
- instr=0xFFFFFFFF: with ILLEGAL_HALT_EN, state=9 and halted=1 held for 10 cycles, until reset returns state=0. Without the macro, the FSM returns to FETCH after DECODE with instret unchanged. Separately, assert reset during MEMRD → next state FETCH with no reg_write.
